keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
Sequences the 4x4 matrix keypad. It drives one row low at a time, samples the active-low columns through a synchronizer, and debounces press and release on the latched key. It emits a single-cycle key event with a hex code. It sits between the keypad pins and the two-digit seven-segment display logic in the lab3 top level, and replaces ad-hoc scanner/debouncer coupling with one controller FSM.

Parameters:
SCAN_DIV, 4096, clk cycles each row is driven before columns are sampled (settle time); legal >= 2
DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a press or a release; legal >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
keypad_cols  input  4  raw column pins, active-low, asynchronous to clk
keypad_rows  output  4  row drive, active-low one-hot
key_code  output  4  hex code of the last accepted key
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high while the accepted key remains pressed (HELD or DEBOUNCE_RELEASE)

Behaviour:
- Reset (async, active-high) forces:
  - state=SCAN, row index 0, keypad_rows=4'b1110
  - timers=0, synchronizer flops=4'b1111
  - key_code=4'h0, key_valid=0, key_held=0
- Synchronizer: keypad_cols passes through 2 flops. All decisions use the synced value cs. Pin-to-decision latency is 2 cycles.
- Counters: row timer width $clog2(SCAN_DIV); debounce counter width $clog2(DEBOUNCE_CYCLES).
- Key map (row,col) row-major: r0: 1 2 3 C; r1: 4 5 6 D; r2: 7 8 9 E; r3: A 0 B F.
- State SCAN:
  - Row timer increments every cycle.
  - At timer==SCAN_DIV-1 with cs==4'b1111: timer clears, row advances (3 wraps to 0), keypad_rows rotates to next one-hot-low pattern.
  - At timer==SCAN_DIV-1 with any cs bit low: latch row and lowest-index low column, clear debounce counter, go to DEBOUNCE_PRESS. Row does not advance.
  - cs is ignored before terminal count.
- State DEBOUNCE_PRESS:
  - Row stays driven.
  - If latched cs bit is low, counter increments.
  - Latched bit low and counter==DEBOUNCE_CYCLES-1: next state HELD; key_code loads the mapped code and key_valid=1 for exactly that one cycle.
  - Latched bit goes high before that point: return to SCAN on the same row, row timer cleared, no key_valid.
  - Net: key_valid rises DEBOUNCE_CYCLES cycles after DEBOUNCE_PRESS entry.
- State HELD:
  - key_held=1; other columns are ignored.
  - Latched bit high: go to DEBOUNCE_RELEASE, counter cleared.
- State DEBOUNCE_RELEASE:
  - key_held stays 1.
  - Latched bit low: return to HELD, no new key_valid (bounce).
  - Latched bit high for DEBOUNCE_CYCLES consecutive cycles: key_held=0, go to SCAN, advance to next row, timer cleared.
- key_code holds its value until the next accepted press. It is never cleared by release.
- Simultaneous keys:
  - Same row: lowest column index wins.
  - Different rows: first row scanned wins.
  - A second key pressed while HELD is not reported. After release it is found on a later scan.
- Reset mid-debounce or mid-hold: immediate return to reset values, no key_valid emitted.
- key_valid is never high two consecutive cycles. At most one key_valid per press-release cycle.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a keypad model: cols[c]=0 iff the modelled key is at (r,c) and rows[r]=0.
- No key, 40 cycles after reset -> keypad_rows cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never 1; key_code=0.
- Press (r2,c1) held 100 cycles -> rows freeze at 1011; exactly one key_valid pulse with key_code=4'h8, 8 cycles after DEBOUNCE_PRESS entry; key_held=1 until release; then key_held=0 8 cycles after release seen and rows resume at 0111.
- Press (r0,c3) with 3-cycle bounce (low 3, high 2, then low) -> no key_valid during bounce; single key_valid with key_code=4'hC; release bounce (high 3, low 2, high) -> key_held stays 1 through bounce, single release.
- All 16 keys pressed and released in sequence -> key_code sequence 1,2,3,C,4,5,6,D,7,8,9,E,A,0,B,F, one key_valid each.
- Keys (r1,c0) and (r1,c2) pressed together -> key_code=4'h4 only; then release c0 while c2 held -> no second key_valid until full release and rescan, then 4'h6.
- Assert reset during DEBOUNCE_PRESS and during HELD -> outputs immediately return to rows=1110, key_valid=0, key_held=0, key_code=0.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad controller: row scan, 2-flop column synchronizer, press/release
// debounce on the latched key, one-cycle key_valid pulse with hex key_code.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_cols,
  output logic [3:0] keypad_rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    cs_q, cs_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  logic [1:0]    low_col;
  logic          key_down;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hC;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hD;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
      4'hC: code = 4'hA;  4'hD: code = 4'h0;  4'hE: code = 4'hB;  default: code = 4'hF;
    endcase
    return code;
  endfunction

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cs_q[i]) low_col = 2'(i);
    end
  end

  assign key_down = ~cs_q[col_q];

  always_comb begin
    sync1_d     = keypad_cols;
    cs_d        = sync1_q;
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (cs_q == 4'hF) begin
            row_d = row_q + 2'd1;
          end else begin
            col_d   = low_col;
            cnt_d   = '0;
            state_d = DEB_PRESS;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DEB_PRESS: begin
        if (!key_down) begin
          state_d = SCAN;
          tmr_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          key_code_d  = key_map(row_q, col_q);
          key_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!key_down) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
      end
      DEB_REL: begin
        // A low bounce sends us back to HELD without a new press event.
        if (key_down) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = row_q + 2'd1;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      sync1_q     <= 4'hF;
      cs_q        <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      cs_q        <= cs_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign keypad_rows = ~(4'b0001 << row_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = (state_q == HELD) || (state_q == DEB_REL);

endmodule
